// File: rtl/toggle_event_receiver_pkg.sv
// Shared definitions for toggle-crossing event receivers.
// Holds the FSM encoding and the default parameter values.
package toggle_event_receiver_pkg;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PEND_W      = 4;
    localparam int DEF_CNT_W       = 16;

    localparam int PEND_MAX = (1 << DEF_PEND_W) - 1;

    function automatic int pend_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Asynchronous-reset flop chain that brings a toggle line into the local clock domain.
module toggle_sync
    import toggle_event_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Recovers events from a toggle line, queues them in a saturating counter and
// hands them out one at a time on a valid/ready interface.
module toggle_event_receiver
    import toggle_event_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PEND_W      = DEF_PEND_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    input  logic              enable,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [PEND_W-1:0] PEND_FULL = {PEND_W{1'b1}};
    localparam logic [2:0]        INIT_LAST = 3'(SYNC_STAGES);

    logic              sync_out;
    logic              state_q, state_d;
    logic [2:0]        init_cnt_q, init_cnt_d;
    logic              tog_prev_q;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              edge_det, inc, dec, full;

    toggle_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tog_in),
        .q     (sync_out)
    );

    // INIT lets the synchroniser settle so the level present at reset release becomes the reference.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        edge_det   = (state_q == ST_RUN) && (sync_out ^ tog_prev_q);
        inc        = edge_det & enable;
        dec        = valid_q & evt_ready;
        full       = (pend_q == PEND_FULL);

        if (state_q == ST_INIT) begin
            if (init_cnt_q == INIT_LAST) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q + 3'd1;
            end
        end

        if (inc && !dec) begin
            if (!full) begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

        if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A fresh drop in the same cycle as the clear must stay visible.
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (inc && !dec && full) begin
            ovf_d = 1'b1;
        end

        valid_d = (pend_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            tog_prev_q <= 1'b0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            tog_prev_q <= sync_out;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign pending   = pend_q;
    assign evt_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed plus randomized bench for toggle_event_receiver, checked against an
// event-queue model that schedules each toggle to land a fixed number of edges later.
module tb_toggle_event_receiver;

    localparam int SYNC   = 2;
    localparam int PEND_W = 4;
    localparam int CNT_W  = 16;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              tog_in = 1'b0;
    logic              enable = 1'b0;
    logic              evt_ready = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              evt_valid;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  evt_count;
    logic              overflow;

    int nPass = 0;
    int nFail = 0;
    int nTotal = 0;
    int cyc = 0;
    int lastTog = -10;
    int mPend;
    int mCnt;
    bit mOvf;
    int dueQ[$];

    toggle_event_receiver #(
        .SYNC_STAGES (SYNC),
        .PEND_W      (PEND_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tog_in    (tog_in),
        .enable    (enable),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pending   (pending),
        .evt_count (evt_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mPend = 0;
        mCnt  = 0;
        mOvf  = 1'b0;
        dueQ.delete();
    endtask

    // A toggle driven before edge k is seen by the sampling edge k and lands on edge k+SYNC.
    task automatic doToggle();
        tog_in = ~tog_in;
        dueQ.push_back(cyc + 1 + SYNC);
        lastTog = cyc;
    endtask

    task automatic checkOutput(input string tag);
        nTotal += 1;
        assert (pending === PEND_W'(mPend)) nPass += 1;
        else begin
            nFail += 1;
            $error("[TB] FAIL %s pending: got %0d expected %0d", tag, pending, mPend);
        end
        nTotal += 1;
        assert (evt_valid === (mPend != 0)) nPass += 1;
        else begin
            nFail += 1;
            $error("[TB] FAIL %s evt_valid: got %0b expected %0b", tag, evt_valid, mPend != 0);
        end
        nTotal += 1;
        assert (evt_count === CNT_W'(mCnt)) nPass += 1;
        else begin
            nFail += 1;
            $error("[TB] FAIL %s evt_count: got %0d expected %0d", tag, evt_count, mCnt);
        end
        nTotal += 1;
        assert (overflow === mOvf) nPass += 1;
        else begin
            nFail += 1;
            $error("[TB] FAIL %s overflow: got %0b expected %0b", tag, overflow, mOvf);
        end
    endtask

    task automatic applyStimulus(input int n, input string tag);
        bit due, inc, dec, setOvf;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc += 1;
            due = (dueQ.size() > 0) && (dueQ[0] == cyc);
            if (due) void'(dueQ.pop_front());
            inc    = due && enable;
            dec    = (mPend != 0) && evt_ready;
            setOvf = inc && !dec && (mPend == PMAX);
            if (inc && !dec && mPend < PMAX) mPend += 1;
            if (dec && !inc) mPend -= 1;
            if (inc) mCnt = (mCnt + 1) % (1 << CNT_W);
            mOvf = setOvf ? 1'b1 : (clr_ovf ? 1'b0 : mOvf);
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    initial begin
        modelReset();
        tog_in = 1'b1;
        #12;
        checkOutput("in_reset");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(10, "ref_level");

        enable = 1'b1;
        repeat (3) begin
            doToggle();
            applyStimulus(4, "three_toggles");
        end

        evt_ready = 1'b1;
        applyStimulus(3, "drain");
        evt_ready = 1'b0;
        applyStimulus(2, "drained");

        repeat (16) begin
            doToggle();
            applyStimulus(2, "saturate");
        end
        applyStimulus(3, "saturated");
        clr_ovf = 1'b1;
        applyStimulus(1, "clr_ovf");
        clr_ovf = 1'b0;
        applyStimulus(1, "after_clr");

        doToggle();
        applyStimulus(2, "full_pre");
        evt_ready = 1'b1;
        applyStimulus(1, "full_inc_dec");
        evt_ready = 1'b0;
        applyStimulus(2, "full_post");

        enable = 1'b0;
        doToggle();
        applyStimulus(4, "disabled_a");
        doToggle();
        applyStimulus(4, "disabled_b");
        enable = 1'b1;
        applyStimulus(3, "reenable");
        doToggle();
        applyStimulus(4, "reenable_toggle");

        repeat (300) begin
            evt_ready = 1'($urandom % 2);
            clr_ovf   = (($urandom % 16) == 0);
            if (($urandom % 8) == 0) enable = ~enable;
            if ((cyc - lastTog) >= 2 && ($urandom % 2) == 1) doToggle();
            applyStimulus(1, "random");
        end
        clr_ovf = 1'b0;
        enable  = 1'b1;
        evt_ready = 1'b0;
        applyStimulus(4, "settle");

        evt_ready = 1'b1;
        applyStimulus(20, "empty");
        evt_ready = 1'b0;
        repeat (5) begin
            doToggle();
            applyStimulus(2, "queue5");
        end
        applyStimulus(3, "queue5_done");

        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(10, "reinit");
        doToggle();
        applyStimulus(4, "post_reset_toggle");

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
